// File: rtl/fnd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fnd_display_scheduler
// Description : Chooses which sensor reading (humidity or temperature) drives
//               the shared 4-digit FND. It keeps a complete 16-bit BCD
//               snapshot of each source, selects a source from a manual mode
//               code or by automatic rotation, and blanks the display while
//               the selected source is stale.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active low
//   tick_1ms   in   1   one-cycle enable, once per millisecond
//   switch_mod in   4   9=manual humidity, 10=manual temp, 11=auto, else hold
//   hum_bcd    in  16   humidity BCD {thousands,hundreds,tens,ones}
//   hum_valid  in   1   hum_bcd valid strobe
//   temp_bcd   in  16   temperature BCD {thousands,hundreds,tens,ones}
//   temp_valid in   1   temp_bcd valid strobe
//   disp_bcd   out 16   digits to the scan driver, 4'hF = blank digit
//   disp_dp    out  4   active-low decimal-point mask, [0]=ones
//   disp_src   out  1   0 = humidity shown, 1 = temperature shown
//   disp_stale out  1   shown source is stale, display blanked
//   mode_auto  out  1   scheduler is in an automatic-rotation state
// ============================================================================
module fnd_display_scheduler #(
    parameter int ROT_MS   = 3000,
    parameter int STALE_MS = 5000,
    parameter int CNT_W    = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic [3:0]  switch_mod,
    input  logic [15:0] hum_bcd,
    input  logic        hum_valid,
    input  logic [15:0] temp_bcd,
    input  logic        temp_valid,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_dp,
    output logic        disp_src,
    output logic        disp_stale,
    output logic        mode_auto
);

    typedef enum logic [1:0] {
        S_MAN_HUM   = 2'd0,
        S_MAN_TEMP  = 2'd1,
        S_AUTO_HUM  = 2'd2,
        S_AUTO_TEMP = 2'd3
    } state_t;

    localparam logic [3:0]       C_MODE_HUM  = 4'd9;
    localparam logic [3:0]       C_MODE_TEMP = 4'd10;
    localparam logic [3:0]       C_MODE_AUTO = 4'd11;
    localparam logic [CNT_W-1:0] C_ROT_LAST  = CNT_W'(ROT_MS - 1);
    localparam logic [CNT_W-1:0] C_STALE     = CNT_W'(STALE_MS);
    localparam logic [3:0]       C_DP_ON     = 4'b1011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rot_cnt_q, rot_cnt_d;
    logic [15:0]        hum_snap_q, temp_snap_q;
    logic [CNT_W-1:0]   hum_age_q, hum_age_d;
    logic [CNT_W-1:0]   temp_age_q, temp_age_d;
    logic [15:0]        disp_bcd_q, disp_bcd_d;
    logic [3:0]         disp_dp_q, disp_dp_d;
    logic               disp_src_q, disp_src_d;
    logic               disp_stale_q, disp_stale_d;

    logic               w_in_auto;
    logic               w_show_temp;
    logic               w_sel_stale;
    logic [15:0]        w_sel_snap;

    // Age since the last valid strobe; a strobe clears even on a tick cycle.
    function automatic logic [CNT_W-1:0] next_age(input logic [CNT_W-1:0] age,
                                                  input logic valid,
                                                  input logic tick);
        if (valid)
            return '0;
        else if (tick && (age != C_STALE))
            return age + CNT_W'(1);
        else
            return age;
    endfunction

    assign w_in_auto   = (state_q == S_AUTO_HUM) || (state_q == S_AUTO_TEMP);
    assign w_show_temp = (state_q == S_MAN_TEMP) || (state_q == S_AUTO_TEMP);

    // Next-state: rotation is evaluated first so a mode code in the same
    // cycle overrides the rotation wrap.
    always_comb begin
        state_d   = state_q;
        rot_cnt_d = rot_cnt_q;

        if (w_in_auto && tick_1ms) begin
            if (rot_cnt_q == C_ROT_LAST) begin
                rot_cnt_d = '0;
                state_d   = (state_q == S_AUTO_HUM) ? S_AUTO_TEMP : S_AUTO_HUM;
            end else begin
                rot_cnt_d = rot_cnt_q + CNT_W'(1);
            end
        end

        if (switch_mod == C_MODE_HUM) begin
            state_d = S_MAN_HUM;
        end else if (switch_mod == C_MODE_TEMP) begin
            state_d = S_MAN_TEMP;
        end else if ((switch_mod == C_MODE_AUTO) && !w_in_auto) begin
            state_d   = S_AUTO_HUM;
            rot_cnt_d = '0;
        end
    end

    assign hum_age_d  = next_age(hum_age_q,  hum_valid,  tick_1ms);
    assign temp_age_d = next_age(temp_age_q, temp_valid, tick_1ms);

    // Output stage works from registered state and snapshots, giving one
    // cycle between a capture/mode change and its appearance on the display.
    assign w_sel_snap  = w_show_temp ? temp_snap_q : hum_snap_q;
    assign w_sel_stale = w_show_temp ? (temp_age_q == C_STALE)
                                     : (hum_age_q == C_STALE);

    always_comb begin
        disp_src_d   = w_show_temp;
        disp_bcd_d   = 16'hFFFF;
        disp_dp_d    = 4'b1111;
        disp_stale_d = 1'b1;
        if (!w_sel_stale) begin
            disp_bcd_d   = w_sel_snap;
            disp_dp_d    = C_DP_ON;
            disp_stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_MAN_HUM;
            rot_cnt_q    <= '0;
            hum_snap_q   <= 16'hFFFF;
            temp_snap_q  <= 16'hFFFF;
            hum_age_q    <= C_STALE;
            temp_age_q   <= C_STALE;
            disp_bcd_q   <= 16'hFFFF;
            disp_dp_q    <= 4'b1111;
            disp_src_q   <= 1'b0;
            disp_stale_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rot_cnt_q    <= rot_cnt_d;
            hum_age_q    <= hum_age_d;
            temp_age_q   <= temp_age_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            disp_src_q   <= disp_src_d;
            disp_stale_q <= disp_stale_d;
            if (hum_valid)
                hum_snap_q <= hum_bcd;
            if (temp_valid)
                temp_snap_q <= temp_bcd;
        end
    end

    assign disp_bcd   = disp_bcd_q;
    assign disp_dp    = disp_dp_q;
    assign disp_src   = disp_src_q;
    assign disp_stale = disp_stale_q;
    assign mode_auto  = w_in_auto;

endmodule
`default_nettype wire
